// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES types, FSM encoding and GF(2^8) helpers.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int Nb = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_t;

    function automatic int nr_width(input int nr);
        return $clog2(nr + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (square-and-multiply), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ============================================================================
// Module  : aes_round (with sub_bytes, shift_rows, mix_columns, add_round_key)
// Brief   : One combinational AES round; final_sel bypasses MixColumns.
// Revision: 1.0 - initial release
// ============================================================================
module sub_bytes
    import aes_pkg::*;
(
    input  logic [0:Nb-1] i_state,
    output logic [0:Nb-1] o_state
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign o_state[8*i +: 8] = sbox(i_state[8*i +: 8]);
    end
endmodule

module shift_rows
    import aes_pkg::*;
(
    input  logic [0:Nb-1] i_state,
    output logic [0:Nb-1] o_state
);
    // Byte 4*c+r sits in row r, column c; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[8*(4*c+r) +: 8] = i_state[8*(4*((c+r)%4)+r) +: 8];
        end
    end
endmodule

module mix_columns
    import aes_pkg::*;
(
    input  logic [0:Nb-1] i_state,
    output logic [0:Nb-1] o_state
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = i_state[32*c      +: 8];
        assign w_a1 = i_state[32*c + 8  +: 8];
        assign w_a2 = i_state[32*c + 16 +: 8];
        assign w_a3 = i_state[32*c + 24 +: 8];
        assign o_state[32*c      +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign o_state[32*c + 8  +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign o_state[32*c + 16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign o_state[32*c + 24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
endmodule

module add_round_key
    import aes_pkg::*;
(
    input  logic [0:Nb-1] i_state,
    input  logic [0:Nb-1] i_round_key,
    output logic [0:Nb-1] o_state
);
    assign o_state = i_state ^ i_round_key;
endmodule

module aes_round
    import aes_pkg::*;
(
    input  logic [0:Nb-1] state,
    input  logic [0:Nb-1] round_key,
    input  logic          final_sel,
    output logic [0:Nb-1] o_state
);
    logic [0:Nb-1] w_sub;
    logic [0:Nb-1] w_shift;
    logic [0:Nb-1] w_mix;
    logic [0:Nb-1] w_pre_key;

    sub_bytes     u_sub   (.i_state(state),     .o_state(w_sub));
    shift_rows    u_shift (.i_state(w_sub),     .o_state(w_shift));
    mix_columns   u_mix   (.i_state(w_shift),   .o_state(w_mix));
    add_round_key u_ark   (.i_state(w_pre_key), .i_round_key(round_key), .o_state(o_state));

    assign w_pre_key = final_sel ? w_shift : w_mix;
endmodule
`default_nettype wire

// File: rtl/aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_sched
// Brief   : Iterative AES encryptor; one shared round datapath, Nr+1 cycles.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int Nr = 10,
    parameter int Nk = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:127]            in_data,
    input  logic [0:128*(Nr+1)-1]   round_keys,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:127]            out_data,
    output logic                    busy,
    output logic [3:0]              round_idx
);
    // Counter covers the round count implied by either parameter.
    localparam int c_ridx_w = nr_width((Nr > Nk + 6) ? Nr : Nk + 6);
    localparam logic [c_ridx_w-1:0] c_one      = c_ridx_w'(1);
    localparam logic [c_ridx_w-1:0] c_last_mid = c_ridx_w'(Nr - 1);

    logic [0:Nb-1]         w_rk [Nr+1];
    logic [0:Nb-1]         w_round_out;
    logic                  w_final;

    aes_state_t            r_fsm;
    logic [0:Nb-1]         r_state;
    logic [c_ridx_w-1:0]   r_round;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign w_rk[r] = round_keys[Nb*r +: Nb];
    end

    assign w_final = (r_fsm == FINAL);

    aes_round u_round (
        .state     (r_state),
        .round_key (w_rk[r_round]),
        .final_sel (w_final),
        .o_state   (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_data ^ w_rk[0];
                        r_round    <= c_one;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_round_out;
                    r_round <= r_round + c_one;
                    if (r_round == c_last_mid) r_fsm <= FINAL;
                end
                FINAL: begin
                    r_state     <= w_round_out;
                    r_round     <= '0;
                    r_out_valid <= 1'b1;
                    r_fsm       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_out_valid ? r_state : '0;
    assign round_idx = 4'(r_round);
endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_round_sched
// Brief   : Self-checking bench for aes_round_sched (Nr=10 and Nr=14 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_round_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_valid, out_ready, sel14;
    logic [0:127]      in_data;
    logic [0:128*11-1] rk10;
    logic [0:128*15-1] rk14;

    logic in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
    logic [0:127] out_data_a, out_data_b;
    logic [3:0]   round_idx_a, round_idx_b;

    aes_round_sched #(.Nr(10), .Nk(4)) dut10 (
        .clk(clk), .reset(reset), .in_valid(in_valid && !sel14), .in_ready(in_ready_a),
        .in_data(in_data), .round_keys(rk10), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .busy(busy_a), .round_idx(round_idx_a));

    aes_round_sched #(.Nr(14), .Nk(8)) dut14 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel14), .in_ready(in_ready_b),
        .in_data(in_data), .round_keys(rk14), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .busy(busy_b), .round_idx(round_idx_b));

    logic in_ready_s, out_valid_s, busy_s;
    logic [0:127] out_data_s;
    logic [3:0]   round_idx_s;
    assign in_ready_s  = sel14 ? in_ready_b  : in_ready_a;
    assign out_valid_s = sel14 ? out_valid_b : out_valid_a;
    assign busy_s      = sel14 ? busy_b      : busy_a;
    assign out_data_s  = sel14 ? out_data_b  : out_data_a;
    assign round_idx_s = sel14 ? round_idx_b : round_idx_a;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t [256];
    logic [0:1919] cur_xk;
    int           cur_nr;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [0:1919] expand_key(input logic [0:255] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [0:1919] xk;
        xk = '0; rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 4*(nr+1); i++) xk[32*i +: 32] = w[i];
        return xk;
    endfunction

    function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:1919] xk, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ xk[8*i +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i + 4*(i%4)) % 16];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c+k];
                    for (int k = 0; k < 4; k++)
                        s[4*c+k] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ xk[128*r + 8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [0:255] key, input bit is14);
        cur_nr = is14 ? 14 : 10;
        cur_xk = expand_key(key, is14 ? 8 : 4, cur_nr);
        sel14  = is14;
        if (is14) rk14 = cur_xk;
        else      rk10 = cur_xk[0:1407];
    endtask

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_block(input string name, input logic [0:127] pt, input logic [0:127] exp,
                             input int stall, input bit noise);
        bit acc;
        int lat;
        logic [0:127] held;
        in_valid = 1'b1; in_data = pt; out_ready = (stall == 0);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_valid && in_ready_s;
            tick();
        end
        checks++;
        if (!acc) begin
            errors++; $display("FAIL %s accept: no accept within 50 cycles", name);
            in_valid = 1'b0;
            return;
        end
        in_valid = noise; in_data = rand128();
        lat = 1;
        while (!out_valid_s && lat <= cur_nr + 5) begin
            checks++;
            if (round_idx_s !== 4'(lat) || busy_s !== 1'b1 || in_ready_s !== 1'b0 || out_data_s !== '0) begin
                errors++;
                $display("FAIL %s edge %0d: round_idx=%0d busy=%b in_ready=%b out_data=%h, want round_idx=%0d busy=1 in_ready=0 out_data=0",
                         name, lat, round_idx_s, busy_s, in_ready_s, out_data_s, lat);
            end
            tick(); lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat != cur_nr + 1) begin
            errors++; $display("FAIL %s latency: out_valid on edge %0d, want %0d", name, lat, cur_nr + 1);
        end
        checks++;
        if (out_data_s !== exp) begin
            errors++; $display("FAIL %s data: got %h want %h", name, out_data_s, exp);
        end
        held = out_data_s;
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (out_valid_s !== 1'b1 || out_data_s !== held || in_ready_s !== 1'b0 || busy_s !== 1'b1) begin
                errors++;
                $display("FAIL %s stall %0d: out_valid=%b out_data=%h in_ready=%b busy=%b, want 1 %h 0 1",
                         name, i, out_valid_s, out_data_s, in_ready_s, busy_s, held);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid_s !== 1'b0 || busy_s !== 1'b0 || in_ready_s !== 1'b1 || out_data_s !== '0 || round_idx_s !== 4'd0) begin
            errors++;
            $display("FAIL %s exit: out_valid=%b busy=%b in_ready=%b out_data=%h round_idx=%0d, want 0 0 1 0 0",
                     name, out_valid_s, busy_s, in_ready_s, out_data_s, round_idx_s);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel14 = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== '0 || busy_a !== 1'b0 || round_idx_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_nr10: in_ready=%b out_valid=%b out_data=%h busy=%b round_idx=%0d, want 1 0 0 0 0",
                     in_ready_a, out_valid_a, out_data_a, busy_a, round_idx_a);
        end
        checks++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_data_b !== '0 || busy_b !== 1'b0 || round_idx_b !== 4'd0) begin
            errors++;
            $display("FAIL reset_nr14: in_ready=%b out_valid=%b out_data=%h busy=%b round_idx=%0d, want 1 0 0 0 0",
                     in_ready_b, out_valid_b, out_data_b, busy_b, round_idx_b);
        end
        in_valid = 1'b1; in_data = rand128();
        tick();
        checks++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b1 || round_idx_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b in_ready=%b round_idx=%0d, want 0 1 0", busy_a, in_ready_a, round_idx_a);
        end
        in_valid = 1'b0; reset = 1'b0;
        tick();
    endtask

    task automatic test_kat_nr10();
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        run_block("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0);
        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        run_block("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b1);
    endtask

    task automatic test_out_stall();
        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        run_block("stall5", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit bad;
        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
        in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_valid && in_ready_s;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && round_idx_s != 4'd5; i++) tick();
        checks++;
        if (round_idx_s !== 4'd5) begin
            errors++; $display("FAIL reset_mid reach: round_idx=%0d want 5", round_idx_s);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || out_valid_s !== 1'b0 || round_idx_s !== 4'd0 || out_data_s !== '0) begin
            errors++;
            $display("FAIL reset_mid state: busy=%b out_valid=%b round_idx=%0d out_data=%h, want 0 0 0 0",
                     busy_s, out_valid_s, round_idx_s, out_data_s);
        end
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_mid discard: out_valid/in_ready moved after reset, want out_valid=0 in_ready=1");
        end
        run_block("c1_after_reset", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [0:127] pt1, pt2, exp1, exp2;
        int acc_cyc[$];
        logic [0:127] outs[$];
        int cyc;
        bit acc;
        set_key({rand128(), 128'h0}, 1'b0);
        pt1 = rand128(); pt2 = rand128();
        exp1 = aes_ref(pt1, cur_xk, cur_nr);
        exp2 = aes_ref(pt2, cur_xk, cur_nr);
        in_valid = 1'b1; in_data = pt1; out_ready = 1'b1;
        cyc = 0;
        while (outs.size() < 2 && cyc < 80) begin
            acc = in_valid && in_ready_s;
            checks++;
            if (in_ready_s === 1'b1 && busy_s === 1'b1) begin
                errors++; $display("FAIL b2b ready_while_busy: cycle %0d in_ready=1 busy=1, want in_ready=0", cyc);
            end
            tick(); cyc++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                in_data = pt2;
            end
            if (out_valid_s) begin
                outs.push_back(out_data_s);
                if (outs.size() == 2) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (acc_cyc.size() != 2 || outs.size() != 2) begin
            errors++; $display("FAIL b2b counts: accepts=%0d outputs=%0d, want 2 2", acc_cyc.size(), outs.size());
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != cur_nr + 2) begin
                errors++; $display("FAIL b2b spacing: %0d cycles want %0d", acc_cyc[1] - acc_cyc[0], cur_nr + 2);
            end
            checks++;
            if (outs[0] !== exp1) begin
                errors++; $display("FAIL b2b data0: got %h want %h", outs[0], exp1);
            end
            checks++;
            if (outs[1] !== exp2) begin
                errors++; $display("FAIL b2b data1: got %h want %h", outs[1], exp2);
            end
        end
    endtask

    task automatic test_kat_nr14();
        set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
        run_block("fips_c3", 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [0:127] pt;
        for (int n = 0; n < 6; n++) begin
            set_key({rand128(), rand128()}, n[0]);
            pt = rand128();
            run_block($sformatf("rand%0d_nr%0d", n, cur_nr), pt, aes_ref(pt, cur_xk, cur_nr),
                      int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel14 = 1'b0;
        in_data = '0; rk10 = '0; rk14 = '0; cur_xk = '0; cur_nr = 10;
        build_sbox();
        test_reset();
        test_kat_nr10();
        test_out_stall();
        test_reset_mid();
        test_back_to_back();
        test_kat_nr14();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter Nr, default 10, number of AES rounds; legal values are 10, 12 and 14.
REQ-002 SHALL have parameter Nk, default 4, key length in 32-bit words; it is informational and is checked against Nr only by the bench.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a plaintext block is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the scheduler accepts a block this cycle.
REQ-007 SHALL have port in_data, input, [0:127]: plaintext; byte 0 is bits [0:7].
REQ-008 SHALL have port round_keys, input, [0:128*(Nr+1)-1]: expanded key; round key r is [128*r +: 128].
REQ-009 SHALL have port out_valid, output, 1 bit: a ciphertext block is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-011 SHALL have port out_data, output, [0:127]: ciphertext.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port round_idx, output, [3:0]: round currently being computed; 0 in IDLE and DONE.

Function
REQ-014 SHALL implement an FSM with states IDLE, ROUND, FINAL and DONE, using one shared round datapath iteratively.
REQ-015 SHALL assert in_ready only in IDLE; a block is accepted on a rising edge where in_valid && in_ready.
REQ-016 On accept, SHALL load state_reg <= in_data XOR round key 0, set round_idx=1, and go to ROUND.
REQ-017 In ROUND, each cycle SHALL load state_reg <= AddRoundKey(MixColumns(ShiftRow(SubBytes(state_reg))), rk[round_idx]) and increment round_idx.
REQ-018 SHALL go from ROUND to FINAL on the edge where round_idx == Nr-1 is processed.
REQ-019 In FINAL, SHALL load state_reg <= AddRoundKey(ShiftRow(SubBytes(state_reg)), rk[Nr]), with MixColumns bypassed, and go to DONE.
REQ-020 Latency: out_valid SHALL rise exactly Nr+1 edges after the accept edge, counting the accept edge as edge 1.
REQ-021 In DONE, SHALL hold out_valid=1 and out_data=state_reg stable until out_valid && out_ready, then return to IDLE.
REQ-022 Back-to-back throughput SHALL be one block per Nr+2 cycles when out_ready is held high.
REQ-023 in_valid asserted outside IDLE SHALL be ignored, with no corruption of the block in flight.
REQ-024 round_keys SHALL be sampled combinationally each cycle; the user holds it stable from accept to the DONE exit, and behaviour is undefined otherwise.
REQ-025 out_data SHALL equal 0 whenever out_valid=0.
REQ-026 round_idx arithmetic SHALL be unsigned 4-bit and never exceed Nr.

Reset
REQ-027 On reset=1 at a rising edge, SHALL enter IDLE with state_reg=0, round_idx=0, in_ready=1 (from the next cycle), out_valid=0, out_data=0 and busy=0.
REQ-028 Reset SHALL take priority over any accept or handshake in the same cycle.
REQ-029 Reset mid-operation SHALL discard the block in flight, producing no out_valid for it.

Structure
REQ-030 Shared package aes_pkg SHALL hold the FSM state encoding, Nb=128 and an Nr-to-width helper.
REQ-031 SHALL instantiate exactly one combinational sub-module, aes_round, with inputs state, round_key and final_sel (MixColumns bypass), built from the existing SubBytes, ShiftRow, MixColumns and AddRoundKey modules.

Verification
REQ-032 Test 1 (Nr=10): in_data 3243f6a8885a308d313198a2e0370734 with the expansion of key 2b7e151628aed2a6abf7158809cf4f3c -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid on edge 11.
REQ-033 Test 2: in_data 00112233445566778899aabbccddeeff with the expansion of key 000102030405060708090a0b0c0d0e0f -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Test 3: out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, IDLE one edge after out_ready=1.
REQ-035 Test 4: reset pulsed while round_idx=5 -> busy=0 and out_valid=0 next cycle; a following FIPS-197 C.1 block still produces the correct result.
REQ-036 Test 5: in_valid held high continuously with out_ready=1 over two vectors -> both correct, accept edges 12 cycles apart, no accept while busy.
REQ-037 Test 6 (Nr=14): with the expansion of key 000102...1f, plaintext 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, out_valid on edge 15.
